// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
// Start/done handshake and operand/result bus of the sequential signed divider.
//   inicio     start request (master -> divider)
//   dividendo  8-bit two's-complement dividend (master -> divider)
//   divisor    4-bit two's-complement divisor (master -> divider)
//   cociente   4-bit two's-complement quotient (divider -> master)
//   resto      4-bit two's-complement remainder, sign of dividend (divider -> master)
//   fin        one-cycle result-ready pulse (divider -> master)
//   ocupado    operation in progress (divider -> master)
//   error      divide-by-zero or quotient overflow on last operation (divider -> master)
// Signals are carried as raw bit vectors; the divider interprets them as signed.
// -----------------------------------------------------------------------------
interface div_seq_if;
    logic       inicio;
    logic [7:0] dividendo;
    logic [3:0] divisor;
    logic [3:0] cociente;
    logic [3:0] resto;
    logic       fin;
    logic       ocupado;
    logic       error;

    modport master (
        output inicio, dividendo, divisor,
        input  cociente, resto, fin, ocupado, error
    );

    modport slave (
        input  inicio, dividendo, divisor,
        output cociente, resto, fin, ocupado, error
    );
endinterface

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Sequential signed divider pairing with the 4x4 Booth multiplier: 8-bit
// dividend / 4-bit divisor -> 4-bit quotient and 4-bit remainder. Restoring
// division on magnitudes, one quotient bit per clock (8 cycles), followed by a
// sign-correction / overflow-check cycle. Latency from accepting edge to fin is
// 9 cycles; a new start is accepted in the fin cycle.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    div_seq_if.slave: inicio/dividendo/divisor in,
//          cociente/resto/fin/ocupado/error out (all registered)
// -----------------------------------------------------------------------------
module div_seq (
    input  logic       clk,
    input  logic       reset,
    div_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        DIVIDE  = 2'd1,
        CORRIGE = 2'd2
    } state_t;

    // Magnitude of an 8-bit signed value; -128 maps to 128 as unsigned.
    function automatic logic [7:0] mag8(input logic signed [7:0] v);
        mag8 = v[7] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Magnitude of a 4-bit signed value; -8 maps to 8 as unsigned.
    function automatic logic [3:0] mag4(input logic signed [3:0] v);
        mag4 = v[3] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Re-apply a sign to a 4-bit magnitude (magnitude 8 with neg gives -8).
    function automatic logic signed [3:0] apply_sign(input logic [3:0] m,
                                                     input logic       neg);
        apply_sign = neg ? -$signed(m) : $signed(m);
    endfunction

    state_t            state, state_nxt;
    logic [7:0]        d_reg, d_nxt;        // dividend shifting out / quotient shifting in
    logic [3:0]        m_reg, m_nxt;        // divisor magnitude
    logic [4:0]        r_reg, r_nxt;        // partial remainder
    logic [2:0]        cnt_reg, cnt_nxt;
    logic              sign_quo, sign_quo_nxt;
    logic              sign_rem, sign_rem_nxt;
    logic              cero, cero_nxt;
    logic signed [3:0] cociente_reg, cociente_nxt;
    logic signed [3:0] resto_reg, resto_nxt;
    logic              fin_reg, fin_nxt;
    logic              ocupado_reg, ocupado_nxt;
    logic              error_reg, error_nxt;

    logic [4:0]        trial;
    logic              trial_ge;
    logic              ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= REPOSO;
            d_reg        <= '0;
            m_reg        <= '0;
            r_reg        <= '0;
            cnt_reg      <= '0;
            sign_quo     <= 1'b0;
            sign_rem     <= 1'b0;
            cero         <= 1'b0;
            cociente_reg <= '0;
            resto_reg    <= '0;
            fin_reg      <= 1'b0;
            ocupado_reg  <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state        <= state_nxt;
            d_reg        <= d_nxt;
            m_reg        <= m_nxt;
            r_reg        <= r_nxt;
            cnt_reg      <= cnt_nxt;
            sign_quo     <= sign_quo_nxt;
            sign_rem     <= sign_rem_nxt;
            cero         <= cero_nxt;
            cociente_reg <= cociente_nxt;
            resto_reg    <= resto_nxt;
            fin_reg      <= fin_nxt;
            ocupado_reg  <= ocupado_nxt;
            error_reg    <= error_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        d_nxt        = d_reg;
        m_nxt        = m_reg;
        r_nxt        = r_reg;
        cnt_nxt      = cnt_reg;
        sign_quo_nxt = sign_quo;
        sign_rem_nxt = sign_rem;
        cero_nxt     = cero;
        cociente_nxt = cociente_reg;
        resto_nxt    = resto_reg;
        fin_nxt      = 1'b0;
        ocupado_nxt  = ocupado_reg;
        error_nxt    = error_reg;

        // Restoring step: shift the next dividend bit into the remainder and
        // subtract the divisor when it fits. R < M <= 8 always, so R[3:0] holds it.
        trial    = {r_reg[3:0], d_reg[7]};
        trial_ge = (trial >= {1'b0, m_reg});
        ovf      = cero | (sign_quo ? (d_reg > 8'd8) : (d_reg > 8'd7));

        unique case (state)
            REPOSO: begin
                if (bus.inicio) begin
                    d_nxt        = mag8($signed(bus.dividendo));
                    m_nxt        = mag4($signed(bus.divisor));
                    r_nxt        = '0;
                    cnt_nxt      = '0;
                    sign_quo_nxt = bus.dividendo[7] ^ bus.divisor[3];
                    sign_rem_nxt = bus.dividendo[7];
                    cero_nxt     = (bus.divisor == 4'd0);
                    ocupado_nxt  = 1'b1;
                    state_nxt    = DIVIDE;
                end
            end
            DIVIDE: begin
                r_nxt   = trial_ge ? (trial - {1'b0, m_reg}) : trial;
                d_nxt   = {d_reg[6:0], trial_ge};
                cnt_nxt = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    state_nxt = CORRIGE;
                end
            end
            CORRIGE: begin
                // Divide-by-zero ran the same sequence; its datapath result is dropped here.
                if (ovf) begin
                    cociente_nxt = '0;
                    resto_nxt    = '0;
                    error_nxt    = 1'b1;
                end else begin
                    cociente_nxt = apply_sign(d_reg[3:0], sign_quo);
                    resto_nxt    = apply_sign(r_reg[3:0], sign_rem);
                    error_nxt    = 1'b0;
                end
                fin_nxt     = 1'b1;
                ocupado_nxt = 1'b0;
                state_nxt   = REPOSO;
            end
            default: begin
                state_nxt = REPOSO;
            end
        endcase
    end

    assign bus.cociente = cociente_reg;
    assign bus.resto    = resto_reg;
    assign bus.fin      = fin_reg;
    assign bus.ocupado  = ocupado_reg;
    assign bus.error    = error_reg;

endmodule
